// File: rtl/ast_dmx_buf_pkg.sv
// Shared types and helpers for the buffered Avalon-ST demultiplexer (ast_dmx_buf).
package ast_dmx_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } dmx_state_t;

    localparam int CNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum int {
        BUF_ROUTE,
        BUF_BACKPRESSURE,
        BUF_BAD_DIR,
        BUF_DIR_TOGGLE,
        BUF_SINGLE_BEAT,
        BUF_RESET,
        BUF_RANDOM
    } test_case_t;

    // A queued beat is packed as {data, sop, eop, empty, channel}.
    function automatic int beat_width(input int data_w, input int chan_w, input int empty_w);
        return data_w + chan_w + empty_w + 2;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ast_dmx_buf_if.sv
// Avalon-ST bundle for ast_dmx_buf: one sink port plus TX_DIR source ports.
interface ast_dmx_buf_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
);

    logic [DIR_SEL_WIDTH-1:0]                 dir_i;
    logic [DATA_WIDTH-1:0]                    ast_data_i;
    logic                                     ast_startofpacket_i;
    logic                                     ast_endofpacket_i;
    logic                                     ast_valid_i;
    logic [EMPTY_WIDTH-1:0]                   ast_empty_i;
    logic [CHANNEL_WIDTH-1:0]                 ast_channel_i;
    logic                                     ast_ready_o;

    logic [TX_DIR-1:0][DATA_WIDTH-1:0]        ast_data_o;
    logic [TX_DIR-1:0]                        ast_startofpacket_o;
    logic [TX_DIR-1:0]                        ast_endofpacket_o;
    logic [TX_DIR-1:0]                        ast_valid_o;
    logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]       ast_empty_o;
    logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]     ast_channel_o;
    logic [TX_DIR-1:0]                        ast_ready_i;

    modport slave (
        input  dir_i, ast_data_i, ast_startofpacket_i, ast_endofpacket_i,
        input  ast_valid_i, ast_empty_i, ast_channel_i,
        output ast_ready_o,
        output ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        output ast_valid_o, ast_empty_o, ast_channel_o,
        input  ast_ready_i
    );

    modport master (
        output dir_i, ast_data_i, ast_startofpacket_i, ast_endofpacket_i,
        output ast_valid_i, ast_empty_i, ast_channel_i,
        input  ast_ready_o,
        input  ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        input  ast_valid_o, ast_empty_o, ast_channel_o,
        output ast_ready_i
    );

endinterface

// File: rtl/ast_dmx_buf_fifo.sv
// Show-ahead synchronous FIFO used as the per-direction beat buffer of ast_dmx_buf.
module ast_dmx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_n_i && do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

endmodule

// File: rtl/ast_dmx_buf.sv
// Buffered, packet-locked Avalon-ST demultiplexer with one show-ahead FIFO per direction.
// Optional per-direction packet and drop counters are enabled by defining AST_DMX_PKT_CNT_EN.
module ast_dmx_buf
    import ast_dmx_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    ast_dmx_buf_if.slave     bus
`ifdef AST_DMX_PKT_CNT_EN
    ,
    output logic [TX_DIR-1:0][CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]             drop_cnt_o
`endif
);

    localparam int BEAT_W = beat_width(DATA_WIDTH, CHANNEL_WIDTH, EMPTY_WIDTH);

    dmx_state_t                    state;
    dmx_state_t                    state_nxt;
    logic [DIR_SEL_WIDTH-1:0]      sel;
    logic [DIR_SEL_WIDTH-1:0]      sel_nxt;
    logic [DIR_SEL_WIDTH-1:0]      target;
    logic                          dir_ok;
    logic                          forward;
    logic                          ready;
    logic                          accept;
    logic [TX_DIR-1:0]             push;
    logic [TX_DIR-1:0]             pop;
    logic [TX_DIR-1:0]             full;
    logic [TX_DIR-1:0]             empty;
    logic [BEAT_W-1:0]             wbeat;
    logic [TX_DIR-1:0][BEAT_W-1:0] rbeat;

    assign dir_ok = (int'(bus.dir_i) < TX_DIR);
    assign wbeat  = {bus.ast_data_i, bus.ast_startofpacket_i, bus.ast_endofpacket_i,
                     bus.ast_empty_i, bus.ast_channel_i};
    assign bus.ast_ready_o = ready;

    // An SOP beat always re-targets from dir_i; other beats follow the locked sel.
    always_comb begin
        target    = sel;
        forward   = 1'b0;
        state_nxt = state;
        sel_nxt   = sel;
        push      = '0;
        if (bus.ast_startofpacket_i) begin
            target  = bus.dir_i;
            forward = dir_ok;
        end else if (state == FWD) begin
            forward = 1'b1;
        end
        ready  = srst_n_i && (!forward || !full[target]);
        accept = bus.ast_valid_i && ready;
        if (accept) begin
            if (bus.ast_startofpacket_i) begin
                if (dir_ok) begin
                    sel_nxt = bus.dir_i;
                end
                if (bus.ast_endofpacket_i) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = dir_ok ? FWD : DROP;
                end
            end else if (bus.ast_endofpacket_i) begin
                state_nxt = IDLE;
            end
        end
        for (int d = 0; d < TX_DIR; d++) begin
            push[d] = accept && forward && (target == DIR_SEL_WIDTH'(d));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // Source fields are forced to zero while a direction has nothing queued.
    for (genvar d = 0; d < TX_DIR; d++) begin : g_dir
        logic [DATA_WIDTH-1:0]    f_data;
        logic                     f_sop;
        logic                     f_eop;
        logic [EMPTY_WIDTH-1:0]   f_empty;
        logic [CHANNEL_WIDTH-1:0] f_chan;

        ast_dmx_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .srst_n_i (srst_n_i),
            .push_i   (push[d]),
            .wdata_i  (wbeat),
            .pop_i    (pop[d]),
            .rdata_o  (rbeat[d]),
            .full_o   (full[d]),
            .empty_o  (empty[d])
        );

        assign {f_data, f_sop, f_eop, f_empty, f_chan} = rbeat[d];
        assign pop[d]                     = !empty[d] && bus.ast_ready_i[d];
        assign bus.ast_valid_o[d]         = !empty[d];
        assign bus.ast_data_o[d]          = empty[d] ? '0 : f_data;
        assign bus.ast_startofpacket_o[d] = !empty[d] && f_sop;
        assign bus.ast_endofpacket_o[d]   = !empty[d] && f_eop;
        assign bus.ast_empty_o[d]         = empty[d] ? '0 : f_empty;
        assign bus.ast_channel_o[d]       = empty[d] ? '0 : f_chan;
    end

`ifdef AST_DMX_PKT_CNT_EN
    localparam int EOP_BIT = CHANNEL_WIDTH + EMPTY_WIDTH;

    logic [TX_DIR-1:0][CNT_WIDTH-1:0] pkt_cnt;
    logic [CNT_WIDTH-1:0]             drop_cnt;

    // Packets are counted as they leave, so a reset-discarded packet never counts.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            for (int d = 0; d < TX_DIR; d++) begin
                if (pop[d] && rbeat[d][EOP_BIT]) begin
                    pkt_cnt[d] <= sat_inc(pkt_cnt[d]);
                end
            end
            if (accept && !forward) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt;
    assign drop_cnt_o = drop_cnt;
`endif

endmodule
